// File: rtl/data_mem_pkg.sv
// Shared types and elaboration helpers for the pipelined data memory.
package data_mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_e;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic bit rd_lat_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Response delay line: stage 0 tags sit beside the registered RAM output,
// stages 1..RD_LAT carry {valid, err, rdata} to the outputs.
module mem_rsp_pipe #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_i,
    input  logic              we_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [DATA_W-1:0] rsp_rdata_o
);

    logic [RD_LAT:0]   vld_q;
    logic [RD_LAT:0]   err_q;
    logic              we0_q;
    logic [DATA_W-1:0] dat_q [1:RD_LAT];
    logic              rd_ok_c;

    // Only a successful read lets RAM data into the pipe; everything else is 0.
    assign rd_ok_c = vld_q[0] & ~we0_q & ~err_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            we0_q <= 1'b0;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[RD_LAT-1:0], acc_i};
            err_q    <= {err_q[RD_LAT-1:0], err_i & acc_i};
            we0_q    <= we_i & acc_i;
            dat_q[1] <= rd_ok_c ? ram_rdata_i : '0;
            for (int unsigned i = 2; i <= RD_LAT; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rsp_valid_o = vld_q[RD_LAT];
    assign rsp_err_o   = err_q[RD_LAT];
    assign rsp_rdata_o = dat_q[RD_LAT];

endmodule

// File: rtl/data_mem_pipe.sv
// Single-port synchronous data memory with valid/ready requests, byte-lane
// writes, hardware zero-fill after reset and out-of-range flagging.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [DATA_W/8-1:0]      req_be,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned NB    = byte_lanes(DATA_W);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("data_mem_pipe: RD_LAT=%0d outside 1..3", RD_LAT);
    end
    if ((DATA_W % BYTE_W) != 0) begin : g_bad_data_w
        $error("data_mem_pipe: DATA_W=%0d not a multiple of 8", DATA_W);
    end
    if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
        $error("data_mem_pipe: DEPTH=%0d outside 1..2^ADDR_W", DEPTH);
    end

    mem_state_e        state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic              req_ready_q;

    logic              in_range_c;
    logic              acc_c;
    logic [NB-1:0]     mem_we_c;
    logic [IDX_W-1:0]  mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [IDX_W-1:0]  req_idx_c;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] ram_rdata_q;

    assign in_range_c = ({1'b0, req_addr} < DEPTH_A);
    assign req_idx_c  = IDX_W'(req_addr);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            req_ready_q <= (state_d == RUN);
        end
    end

    // Next state: zero-fill sweeps every word once, then serve requests
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Outputs: write port steering and request acceptance; nothing moves under rst
    always_comb begin
        acc_c       = 1'b0;
        mem_we_c    = '0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;
        if (!rst) begin
            case (state_q)
                INIT: begin
                    mem_we_c    = '1;
                    mem_waddr_c = init_cnt_q;
                end
                RUN: begin
                    acc_c       = req_valid & req_ready_q;
                    mem_waddr_c = req_idx_c;
                    mem_wdata_c = req_wdata;
                    if (acc_c && req_we && in_range_c) begin
                        mem_we_c = req_be;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM array: byte-lane write, registered read (no reset so it maps to block RAM)
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (mem_we_c[i]) begin
                mem_q[mem_waddr_c][i*BYTE_W +: BYTE_W] <= mem_wdata_c[i*BYTE_W +: BYTE_W];
            end
        end
        if (acc_c) begin
            ram_rdata_q <= mem_q[req_idx_c];
        end
    end

    mem_rsp_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk         (clk),
        .rst         (rst),
        .acc_i       (acc_c),
        .we_i        (req_we),
        .err_i       (~in_range_c),
        .ram_rdata_i (ram_rdata_q),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_rdata_o (rsp_rdata)
    );

    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench: three instances (RD_LAT 1..3, DEPTH 1000) share one stimulus
// stream; a negedge monitor checks every response against a reference memory.
module tb_data_mem_pipe;

    localparam int DEPTH = 1000;
    localparam int NINST = 3;

    typedef struct {
        int          due;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_be = 2'b00;
    logic [9:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;

    logic [NINST-1:0] rdy;
    logic [NINST-1:0] rv;
    logic [NINST-1:0] re;
    logic [15:0]      rd [NINST];

    exp_t        exp_q [NINST][$];
    logic [15:0] ref_mem [DEPTH];

    int edge_cnt = 0;
    int rst_on   = 0;
    int rst_off  = 0;
    int n_chk    = 0;
    int n_fail   = 0;

    initial forever #5 clk = ~clk;

    for (genvar k = 0; k < NINST; k++) begin : g_dut
        data_mem_pipe #(
            .DATA_W (16),
            .ADDR_W (10),
            .DEPTH  (DEPTH),
            .RD_LAT (k + 1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_ready (rdy[k]),
            .req_we    (req_we),
            .req_be    (req_be),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rv[k]),
            .rsp_rdata (rd[k]),
            .rsp_err   (re[k])
        );
    end

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Monitor: readiness from reset timing, responses popped when due
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            logic exp_rdy;
            exp_t e;
            exp_rdy = (edge_cnt < rst_on) && ((edge_cnt - rst_off) >= DEPTH);
            n_chk++;
            if (rdy[k] !== exp_rdy) begin
                n_fail++;
                $display("FAIL req_ready lat%0d edge %0d: got %b want %b", k+1, edge_cnt, rdy[k], exp_rdy);
            end
            while (exp_q[k].size() > 0 && exp_q[k][0].due < edge_cnt) begin
                e = exp_q[k].pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_rsp lat%0d due edge %0d: got none want err=%b rdata=%h", k+1, e.due, e.err, e.rdata);
            end
            if (exp_q[k].size() > 0 && exp_q[k][0].due == edge_cnt) begin
                e = exp_q[k].pop_front();
                n_chk++;
                if (rv[k] !== 1'b1 || re[k] !== e.err || rd[k] !== e.rdata) begin
                    n_fail++;
                    $display("FAIL rsp lat%0d edge %0d: got v=%b err=%b rdata=%h want v=1 err=%b rdata=%h",
                             k+1, edge_cnt, rv[k], re[k], rd[k], e.err, e.rdata);
                end
            end else begin
                n_chk++;
                if (rv[k] !== 1'b0 || re[k] !== 1'b0 || rd[k] !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL idle lat%0d edge %0d: got v=%b err=%b rdata=%h want all 0",
                             k+1, edge_cnt, rv[k], re[k], rd[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] be, input logic [9:0] addr,
                         input logic [15:0] wd);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        e.err   = (int'(addr) >= DEPTH);
        e.rdata = 16'h0000;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < 2; i++) begin
                    if (be[i]) ref_mem[addr][i*8 +: 8] = wd[i*8 +: 8];
                end
            end else begin
                e.rdata = ref_mem[addr];
            end
        end
        for (int k = 0; k < NINST; k++) begin
            e.due = edge_cnt + 2 + k;
            exp_q[k].push_back(e);
        end
        tick();
        req_valid = 1'b0;
    endtask

    // Assert rst for the next edge, drop responses that edge would flush, zero the model
    task automatic do_reset(input int hold);
        rst    = 1'b1;
        rst_on = edge_cnt + 1;
        for (int k = 0; k < NINST; k++) begin
            while (exp_q[k].size() > 0 && exp_q[k][$].due >= edge_cnt + 1) begin
                void'(exp_q[k].pop_back());
            end
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        repeat (hold) tick();
        rst     = 1'b0;
        rst_off = edge_cnt;
        rst_on  = 32'h7fff_ffff;
    endtask

    initial begin
        logic        we;
        logic [1:0]  be;
        logic [9:0]  addr;
        logic [15:0] wd;

        rst_on = 0;
        do_reset(3);
        repeat (DEPTH) tick();

        // Content written before reset must read back as zero afterwards
        issue(1'b1, 2'b11, 10'd5, 16'hBEEF);
        issue(1'b0, 2'b00, 10'd5, 16'h0000);
        repeat (2) tick();
        do_reset(2);
        repeat (DEPTH) tick();
        issue(1'b0, 2'b00, 10'd5, 16'h0000);

        // Byte lanes
        issue(1'b1, 2'b11, 10'd7, 16'h1234);
        issue(1'b1, 2'b10, 10'd7, 16'hAB00);
        issue(1'b0, 2'b00, 10'd7, 16'h0000);
        issue(1'b1, 2'b00, 10'd7, 16'hFFFF);
        issue(1'b0, 2'b00, 10'd7, 16'h0000);

        // Write then read on the very next cycle
        issue(1'b1, 2'b11, 10'd3, 16'h00FF);
        issue(1'b0, 2'b00, 10'd3, 16'h0000);

        // Out of range: flagged, zero data, no aliasing into implemented words
        issue(1'b0, 2'b00, 10'd1000, 16'h0000);
        issue(1'b1, 2'b11, 10'd1023, 16'h5555);
        issue(1'b0, 2'b00, 10'd1023, 16'h0000);
        issue(1'b0, 2'b00, 10'd23, 16'h0000);
        issue(1'b0, 2'b00, 10'd999, 16'h0000);
        issue(1'b0, 2'b00, 10'd0, 16'h0000);
        issue(1'b1, 2'b11, 10'd999, 16'hC0DE);
        issue(1'b0, 2'b00, 10'd999, 16'h0000);
        tick();

        // Streaming mixed traffic, one request per cycle
        for (int n = 0; n < 64; n++) begin
            we = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(0, 3));
            wd = 16'($urandom);
            if ($urandom_range(0, 9) == 0) addr = 10'(1000 + $urandom_range(0, 23));
            else                           addr = 10'($urandom_range(0, 15));
            issue(we, be, addr, wd);
        end

        // Reset on the cycle right after three reads
        issue(1'b0, 2'b00, 10'd7, 16'h0000);
        issue(1'b0, 2'b00, 10'd3, 16'h0000);
        issue(1'b0, 2'b00, 10'd5, 16'h0000);
        do_reset(1);
        repeat (DEPTH / 2) tick();

        // Reset again in the middle of the zero-fill
        do_reset(2);
        repeat (DEPTH) tick();
        issue(1'b0, 2'b00, 10'd7, 16'h0000);
        issue(1'b0, 2'b00, 10'd3, 16'h0000);
        issue(1'b0, 2'b00, 10'd999, 16'h0000);

        repeat (8) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
